// File: rtl/ir_pkg.sv
// Shared definitions for the IR event arbiter slice.
//   N_CH_DEF / DEBOUNCE_CYC_DEF : default channel count and debounce length
//   EVT_ARRIVE / EVT_DEPART     : evt_kind encodings
//   arb_state_t                 : arbiter FSM state type
package ir_pkg;

   localparam int unsigned N_CH_DEF         = 4;
   localparam int unsigned DEBOUNCE_CYC_DEF = 16;

   localparam logic EVT_ARRIVE = 1'b1;
   localparam logic EVT_DEPART = 1'b0;

   typedef enum logic {
      ARB_IDLE,
      ARB_OFFER
   } arb_state_t;

endpackage

// File: rtl/ir_debounce.sv
// Single-channel IR sensor conditioner: 2-flop synchronizer, stability
// counter and debounced presence level.
//   clk, reset : clock, synchronous active-high reset
//   raw        : asynchronous sensor line, 0 = object present
//   level      : debounced presence, 1 = present
//   toggle     : high in the cycle whose rising edge flips level
module ir_debounce
   import ir_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic toggle
);

   logic [1:0]  sync;
   logic [1:0]  sync_vld;
   logic [15:0] cnt;
   logic        mismatch;

   // The reset contents of the synchronizer are not sensor data, so
   // counting starts only once a sampled value has reached sync[1].
   // raw is active-low, so a change is pending while sync equals level.
   assign mismatch = sync_vld[1] && (sync[1] == level);
   assign toggle   = mismatch && (cnt == 16'(DEBOUNCE_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         sync     <= '0;
         sync_vld <= '0;
         cnt      <= '0;
         level    <= 1'b0;
      end else begin
         sync     <= {sync[0], raw};
         sync_vld <= {sync_vld[0], 1'b1};
         if (toggle) begin
            level <= ~level;
            cnt   <= '0;
         end else if (mismatch) begin
            cnt <= cnt + 16'd1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ir_event_arbiter.sv
// Debounces N_CH IR sensors and offers each presence change as an event
// through a valid/ready handshake, one-deep pending slot per channel,
// round-robin arbitration and a sticky overwrite flag.
//   clk, reset     : clock, synchronous active-high reset
//   ir_sensor_data : raw sensor lines, 0 = object present
//   evt_ready      : downstream accepts the offered event
//   ovf_clr        : pulse clearing ovf
//   evt_valid      : event offered
//   evt_ch         : channel of the offered event
//   evt_kind       : 1 = arrive, 0 = depart
//   ir_detected    : debounced presence per channel
//   led            : registered copy of ir_detected
//   ovf            : sticky, a pending event was overwritten
module ir_event_arbiter
   import ir_pkg::*;
#(
   parameter int unsigned N_CH         = N_CH_DEF,
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   localparam int unsigned CW          = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] ir_sensor_data,
   input  logic            evt_ready,
   input  logic            ovf_clr,
   output logic            evt_valid,
   output logic [CW-1:0]   evt_ch,
   output logic            evt_kind,
   output logic [N_CH-1:0] ir_detected,
   output logic [N_CH-1:0] led,
   output logic            ovf
);

   logic [N_CH-1:0] det;
   logic [N_CH-1:0] tgl;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] kind;
   logic [N_CH-1:0] grant_clr;
   logic [CW-1:0]   last_grant;
   logic [CW-1:0]   grant_idx;
   logic            grant_found;
   logic            grant_fire;
   logic            handshake;
   logic            ovf_set;
   int unsigned     pos;
   arb_state_t      state, state_next;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ir_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .raw    (ir_sensor_data[g]),
         .level  (det[g]),
         .toggle (tgl[g])
      );
   end

   assign ir_detected = det;

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      pos         = 0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         pos = (32'(last_grant) + k) % N_CH;
         if (!grant_found && pend[pos]) begin
            grant_found = 1'b1;
            grant_idx   = CW'(pos);
         end
      end
   end

   always_comb begin
      state_next = state;
      grant_fire = 1'b0;
      handshake  = 1'b0;
      evt_valid  = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (grant_found) begin
               grant_fire = 1'b1;
               state_next = ARB_OFFER;
            end
         end
         ARB_OFFER: begin
            evt_valid = 1'b1;
            if (evt_ready) begin
               handshake  = 1'b1;
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      grant_clr = '0;
      if (grant_fire) grant_clr[grant_idx] = 1'b1;
   end

   // A slot being granted this cycle is delivered, so a toggle landing on
   // it is a fresh event rather than an overwrite.
   assign ovf_set = |(tgl & pend & ~grant_clr);

   always_ff @(posedge clk) begin
      if (reset) state <= ARB_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         evt_ch     <= '0;
         evt_kind   <= EVT_DEPART;
         last_grant <= CW'(N_CH - 1);
         pend       <= '0;
         kind       <= '0;
         led        <= '0;
         ovf        <= 1'b0;
      end else begin
         if (grant_fire) begin
            evt_ch   <= grant_idx;
            evt_kind <= kind[grant_idx];
         end
         if (handshake) last_grant <= evt_ch;
         // Set wins over the grant clear; new kind is the post-toggle level.
         pend <= (pend & ~grant_clr) | tgl;
         kind <= (kind & ~tgl) | (~det & tgl);
         led  <= det ^ tgl;
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ir_event_arbiter.sv
// Self-checking bench for ir_event_arbiter (N_CH = 4, DEBOUNCE_CYC = 16).
// Expected events are queued when stimulus is applied and compared as the
// DUT hands them off.
module tb_ir_event_arbiter;

   typedef struct packed {
      logic [1:0] ch;
      logic       kind;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ir_sensor_data;
   logic       evt_ready;
   logic       ovf_clr;
   logic       evt_valid;
   logic [1:0] evt_ch;
   logic       evt_kind;
   logic [3:0] ir_detected;
   logic [3:0] led;
   logic       ovf;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   exp_t mon_e;
   bit   gap_pend = 1'b0;

   ir_event_arbiter #(
      .N_CH         (4),
      .DEBOUNCE_CYC (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ir_sensor_data (ir_sensor_data),
      .evt_ready      (evt_ready),
      .ovf_clr        (ovf_clr),
      .evt_valid      (evt_valid),
      .evt_ch         (evt_ch),
      .evt_kind       (evt_kind),
      .ir_detected    (ir_detected),
      .led            (led),
      .ovf            (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic kind);
      exp_t e;
      e.ch   = 2'(ch);
      e.kind = kind;
      sb.push_back(e);
   endtask

   task automatic wait_valid(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (evt_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
      tick();
      tick();
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   // Handshake monitor: inputs are stable at the falling edge, so
   // valid && ready here means the next rising edge completes a transfer.
   always @(negedge clk) begin
      if (gap_pend) begin
         check("gap_low", 32'(evt_valid), 32'd0);
         gap_pend = 1'b0;
      end
      if (!reset && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_evt", {30'd0, evt_ch}, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check("evt_ch", 32'(evt_ch), 32'(mon_e.ch));
            check("evt_kind", 32'(evt_kind), 32'(mon_e.kind));
         end
         gap_pend = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      ir_sensor_data = 4'hF;
      evt_ready      = 1'b0;
      ovf_clr        = 1'b0;
      repeat (3) tick();
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_ch", 32'(evt_ch), 32'd0);
      check("rst_kind", 32'(evt_kind), 32'd0);
      check("rst_det", 32'(ir_detected), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      reset = 1'b0;

      // Channel 0 arrive: detected 18 cycles after the drop, offered one later.
      evt_ready = 1'b1;
      repeat (10) tick();
      ir_sensor_data[0] = 1'b0;
      push(0, 1'b1);
      repeat (17) tick();
      check("a_det_early", 32'(ir_detected[0]), 32'd0);
      tick();
      check("a_det", 32'(ir_detected[0]), 32'd1);
      check("a_led", 32'(led[0]), 32'd1);
      check("a_valid_early", 32'(evt_valid), 32'd0);
      tick();
      check("a_valid", 32'(evt_valid), 32'd1);
      check("a_ch", 32'(evt_ch), 32'd0);
      check("a_kind", 32'(evt_kind), 32'd1);
      drain("a_drain");

      // Channel 1: two 15-cycle glitches separated by a short high gap.
      for (int r = 0; r < 2; r++) begin
         ir_sensor_data[1] = 1'b0;
         repeat (15) tick();
         ir_sensor_data[1] = 1'b1;
         repeat (3) tick();
      end
      repeat (25) tick();
      check("glitch_det", 32'(ir_detected[1]), 32'd0);
      check("glitch_valid", 32'(evt_valid), 32'd0);

      // Reset during OFFER drops the event; sensors held low through reset.
      evt_ready = 1'b0;
      ir_sensor_data[0] = 1'b1;
      wait_valid("d_wait");
      check("d_ch", 32'(evt_ch), 32'd0);
      check("d_kind", 32'(evt_kind), 32'd0);
      ir_sensor_data = 4'h0;
      reset = 1'b1;
      tick();
      check("d_rst_valid", 32'(evt_valid), 32'd0);
      check("d_rst_ch", 32'(evt_ch), 32'd0);
      check("d_rst_kind", 32'(evt_kind), 32'd0);
      check("d_rst_det", 32'(ir_detected), 32'd0);
      check("d_rst_led", 32'(led), 32'd0);
      check("d_rst_ovf", 32'(ovf), 32'd0);
      tick();
      reset = 1'b0;
      evt_ready = 1'b1;
      for (int c = 0; c < 4; c++) push(c, 1'b1);
      repeat (17) tick();
      check("d_det_early", 32'(ir_detected), 32'd0);
      tick();
      check("d_det", 32'(ir_detected), 32'hF);
      check("d_led", 32'(led), 32'hF);
      drain("d_drain");

      // All depart with evt_ready low: the first offer must hold still.
      evt_ready = 1'b0;
      ir_sensor_data = 4'hF;
      for (int c = 0; c < 4; c++) push(c, 1'b0);
      wait_valid("e_wait");
      for (int i = 0; i < 50; i++) begin
         check("e_hold_valid", 32'(evt_valid), 32'd1);
         check("e_hold_ch", 32'(evt_ch), 32'd0);
         check("e_hold_kind", 32'(evt_kind), 32'd0);
         tick();
      end
      evt_ready = 1'b1;
      drain("e_drain");

      // Channel 2 arrive then depart while pending behind channel 3.
      evt_ready = 1'b0;
      ir_sensor_data[3] = 1'b0;
      push(3, 1'b1);
      wait_valid("f_wait");
      check("f_ch", 32'(evt_ch), 32'd3);
      ir_sensor_data[2] = 1'b0;
      repeat (25) tick();
      check("f_ovf_arrive", 32'(ovf), 32'd0);
      ir_sensor_data[2] = 1'b1;
      repeat (25) tick();
      check("f_ovf_set", 32'(ovf), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("f_ovf_clr", 32'(ovf), 32'd0);
      push(2, 1'b0);
      evt_ready = 1'b1;
      drain("f_drain");
      check("f_det", 32'(ir_detected), 32'h8);
      check("end_valid", 32'(evt_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
